adder_operand_issuer: RTL and testbench

Upstream feeder for the registered 4-bit adder stage. It buffers operand pairs that arrive on a valid/ready interface in a small FIFO. It issues at most one pair per cycle on registered a_out/b_out outputs, which connect directly to the adder's a/b inputs. It also generates res_valid, a valid flag delayed to line up with the adder's registered sum c, so downstream logic knows which c values are real.

---
 rtl/adder_operand_issuer.sv | 119 +++++++++++
 tb/tb_adder_operand_issuer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_operand_issuer.sv
// adder_operand_issuer
//
// Feeds the registered WIDTH-bit adder stage. Operand pairs arrive on a
// valid/ready interface and are buffered in a DEPTH-entry FIFO. At most one
// pair per cycle is issued onto the registered a_out/b_out outputs, which
// drive the adder's a/b inputs directly. res_valid is issue_valid delayed by
// ADDER_LAT cycles, so it is high exactly when the adder's sum c belongs to a
// freshly issued pair.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready producer handshake; in_ready = !full
//   in_a, in_b        operand pair from the producer
//   issue_en          permission to issue the head pair this cycle
//   a_out, b_out      registered operands to the adder (hold when not issuing)
//   issue_valid       a_out/b_out carry a newly issued pair this cycle
//   res_valid         the adder's c carries the sum of an issued pair
//   count/full/empty  FIFO occupancy status
module adder_operand_issuer #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter int ADDER_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     issue_en,
  output logic [WIDTH-1:0]         a_out,
  output logic [WIDTH-1:0]         b_out,
  output logic                     issue_valid,
  output logic                     res_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [2*WIDTH-1:0] head;
  logic               push;
  logic               pop;
  logic [ADDER_LAT-1:0] res_pipe;

  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  assign in_ready = !full;

  // Pop only looks at the registered count, so a pair written this cycle is
  // never issued in the same cycle (no fall-through), and a full FIFO refuses
  // a push even when it also pops (no bypass).
  assign push = in_valid && in_ready;
  assign pop  = issue_en && !empty;
  assign head = mem[rd_ptr];

  // NOTE: the storage array has no reset; entries are only read after being
  // written, and leaving it unreset lets it map onto plain RAM/flops without
  // a reset tree.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_a, in_b};
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are AW bits wide and DEPTH is a power of two, so they wrap
      // modulo DEPTH on their own.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue register: operands hold their last value when nothing is issued,
  // so the adder keeps recomputing the old sum; res_valid masks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_out       <= '0;
      b_out       <= '0;
      issue_valid <= 1'b0;
    end else begin
      issue_valid <= pop;
      if (pop) begin
        a_out <= head[2*WIDTH-1:WIDTH];
        b_out <= head[WIDTH-1:0];
      end
    end
  end

  // Delay line matching the adder's latency; cleared on reset so results of
  // pairs in flight at reset time are never flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_pipe <= '0;
    end else begin
      res_pipe[0] <= issue_valid;
      for (int i = 1; i < ADDER_LAT; i++) res_pipe[i] <= res_pipe[i-1];
    end
  end

  assign res_valid = res_pipe[ADDER_LAT-1];

endmodule

// File: tb/tb_adder_operand_issuer.sv
// Testbench for adder_operand_issuer with a behavioural registered 4-bit
// adder on a_out/b_out. The stimulus thread drives directed vectors (each
// carrying its hand-computed sum), tracks occupancy and pushes expected pairs
// into a scoreboard queue; a monitor on the falling edge pops and compares
// whenever issue_valid / res_valid are presented.
module tb_adder_operand_issuer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       issue_en = 1'b0;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic       issue_valid;
  logic       res_valid;
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic [3:0] c;

  adder_operand_issuer #(.WIDTH(4), .DEPTH(4), .ADDER_LAT(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .issue_en    (issue_en),
    .a_out       (a_out),
    .b_out       (b_out),
    .issue_valid (issue_valid),
    .res_valid   (res_valid),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  // Downstream registered adder: carry is dropped.
  always @(posedge clk) c <= a_out + b_out;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] s;
  } pair_t;

  pair_t      pq[$];
  logic [3:0] sq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         mdl_cnt = 0;
  logic       exp_iv = 1'b0;
  logic       in_reset = 1'b1;
  logic       rv_prev = 1'b0;
  logic [3:0] last_a = '0;
  logic [3:0] last_b = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: check status against the occupancy model, drive inputs, and
  // record what the coming edge must do.
  task automatic tick(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] s, input logic ie);
    logic psh;
    logic pp;
    check("in_ready", 32'(in_ready), 32'(mdl_cnt != 4));
    check("count", 32'(count), 32'(mdl_cnt));
    check("full", 32'(full), 32'(mdl_cnt == 4));
    check("empty", 32'(empty), 32'(mdl_cnt == 0));
    check("issue_valid", 32'(issue_valid), 32'(exp_iv));
    in_valid = v;
    in_a     = a;
    in_b     = b;
    issue_en = ie;
    psh = v && (mdl_cnt != 4);
    pp  = ie && (mdl_cnt != 0);
    if (psh) pq.push_back('{a: a, b: b, s: s});
    exp_iv  = pp;
    mdl_cnt = mdl_cnt + int'(psh) - int'(pp);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_reset = 1'b1;
    in_valid = 1'b0;
    issue_en = 1'b0;
    pq.delete();
    sq.delete();
    mdl_cnt = 0;
    exp_iv  = 1'b0;
    @(negedge clk);
    #1;
    rst      = 1'b0;
    in_reset = 1'b0;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_a_out", 32'(a_out), 32'd0);
    check("rst_b_out", 32'(b_out), 32'd0);
    check("rst_issue_valid", 32'(issue_valid), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard.
  always @(negedge clk) begin
    if (in_reset) begin
      last_a  = '0;
      last_b  = '0;
      rv_prev = 1'b0;
    end else begin
      check("res_valid", 32'(res_valid), 32'(rv_prev));
      if (res_valid) begin
        check("sum_available", 32'(sq.size() != 0), 32'd1);
        if (sq.size() != 0) check("c_sum", 32'(c), 32'(sq.pop_front()));
      end
      if (issue_valid) begin
        check("pair_available", 32'(pq.size() != 0), 32'd1);
        if (pq.size() != 0) begin
          pair_t e;
          e = pq.pop_front();
          check("a_out", 32'(a_out), 32'(e.a));
          check("b_out", 32'(b_out), 32'(e.b));
          sq.push_back(e.s);
          last_a = e.a;
          last_b = e.b;
        end
      end else begin
        check("a_hold", 32'(a_out), 32'(last_a));
        check("b_hold", 32'(b_out), 32'(last_b));
      end
      rv_prev = issue_valid;
    end
  end

  // Pairs with hand-computed 4-bit sums for the wrap test (several overflow).
  pair_t wrap_vec[12] = '{
    '{a: 4'd15, b: 4'd1,  s: 4'd0},  '{a: 4'd12, b: 4'd7,  s: 4'd3},
    '{a: 4'd6,  b: 4'd9,  s: 4'd15}, '{a: 4'd8,  b: 4'd8,  s: 4'd0},
    '{a: 4'd10, b: 4'd11, s: 4'd5},  '{a: 4'd13, b: 4'd14, s: 4'd11},
    '{a: 4'd3,  b: 4'd2,  s: 4'd5},  '{a: 4'd0,  b: 4'd0,  s: 4'd0},
    '{a: 4'd14, b: 4'd3,  s: 4'd1},  '{a: 4'd11, b: 4'd4,  s: 4'd15},
    '{a: 4'd5,  b: 4'd12, s: 4'd1},  '{a: 4'd2,  b: 4'd15, s: 4'd1}
  };

  initial begin
    @(negedge clk);
    #1;
    do_reset();

    // 1: single pair, 9+8 wraps to 1.
    tick(1'b1, 4'd9, 4'd8, 4'd1, 1'b1);
    tick(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    repeat (2) tick(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);

    // 2: fill to full with issue disabled; (5,5) is held back until room.
    for (int i = 1; i <= 4; i++)
      tick(1'b1, 4'(i), 4'(i), 4'(2 * i), 1'b0);
    check("t2_count", 32'(count), 32'd4);
    check("t2_full", 32'(full), 32'd1);
    check("t2_in_ready", 32'(in_ready), 32'd0);
    tick(1'b1, 4'd5, 4'd5, 4'd10, 1'b0);
    tick(1'b1, 4'd5, 4'd5, 4'd10, 1'b1);
    tick(1'b1, 4'd5, 4'd5, 4'd10, 1'b1);
    repeat (5) tick(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);

    // 3: hold count at 2 with simultaneous push/issue across pointer wrap.
    tick(1'b1, wrap_vec[0].a, wrap_vec[0].b, wrap_vec[0].s, 1'b0);
    tick(1'b1, wrap_vec[1].a, wrap_vec[1].b, wrap_vec[1].s, 1'b0);
    for (int i = 2; i < 12; i++) begin
      tick(1'b1, wrap_vec[i].a, wrap_vec[i].b, wrap_vec[i].s, 1'b1);
      check("t3_count", 32'(count), 32'd2);
    end
    repeat (4) tick(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);

    // 4: push into empty with issue_en high does not fall through.
    tick(1'b1, 4'd7, 4'd7, 4'd14, 1'b1);
    check("t4_no_fallthrough", 32'(issue_valid), 32'd0);
    tick(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("t4_issue", 32'(issue_valid), 32'd1);
    check("t4_a_out", 32'(a_out), 32'd7);

    // 6: issue_en on an empty FIFO: nothing issued, operands hold at 7.
    repeat (6) tick(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("t6_a_hold", 32'(a_out), 32'd7);
    check("t6_b_hold", 32'(b_out), 32'd7);

    // 5: reset with three pairs buffered and one in flight.
    for (int i = 0; i < 4; i++)
      tick(1'b1, 4'(2 * i + 1), 4'(2 * i + 2), 4'(4 * i + 3), 1'b0);
    tick(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("t5_pre_count", 32'(count), 32'd3);
    do_reset();

    // Recovery after reset.
    tick(1'b1, 4'd9, 4'd8, 4'd1, 1'b1);
    repeat (4) tick(1'b0, 4'd0, 4'd0, 4'd0, 1'b1);
    check("drain_pairs", 32'(pq.size()), 32'd0);
    check("drain_sums", 32'(sq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
